div_unit: RTL and testbench

//  Multi-cycle 32-bit signed/unsigned divider for DIV/DIVU. Sits beside the EX stage and

---
 rtl/div_unit_pkg.sv | 16 +
 rtl/div_unit.sv | 122 ++++++++++++
 tb/tb_div_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states and ready/start levels.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 DIV/DIVU divider producing {remainder, quotient}, one quotient bit per cycle.
// Latency: ready_o at edge WIDTH+1 after start_i is sampled; divide-by-zero answers at edge 2.
// Backpressure: result_o/ready_o hold in END until the requester drops start_i; annul_i flushes ON/BYZERO.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               Rst_n,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   work;
    logic [WIDTH-1:0]   divisor;
    logic               neg_q;
    logic               neg_r;

    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   dvd_abs;
    logic [WIDTH-1:0]   dvs_abs;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   q_raw;
    logic [WIDTH-1:0]   r_raw;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign dvd_abs = op1_neg ? -opdata1_i : opdata1_i;
    assign dvs_abs = op2_neg ? -opdata2_i : opdata2_i;

    // Trial subtraction of the divisor from the current partial remainder.
    assign diff  = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

    assign q_raw = work[WIDTH-1:0];
    assign r_raw = work[2*WIDTH:WIDTH+1];
    assign q_fix = neg_q ? -q_raw : q_raw;
    assign r_fix = neg_r ? -r_raw : r_raw;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    result_o <= '0;
                    ready_o  <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        cnt     <= '0;
                        divisor <= dvs_abs;
                        neg_q   <= op1_neg ^ op2_neg;
                        neg_r   <= op1_neg;
                        work    <= {{WIDTH{1'b0}}, dvd_abs, 1'b0};
                        state   <= (opdata2_i == '0) ? DivByZero : DivOn;
                    end
                end

                // The zero-divisor answer waits one extra cycle so it lands at edge 2.
                DivByZero: begin
                    if (annul_i) begin
                        state    <= DivFree;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end else if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        state    <= DivEnd;
                        result_o <= '0;
                        ready_o  <= DivResultReady;
                    end
                end

                DivOn: begin
                    if (annul_i) begin
                        state    <= DivFree;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end else if (cnt != CNT_W'(WIDTH)) begin
                        if (diff[WIDTH])
                            work <= {work[2*WIDTH-1:0], 1'b0};
                        else
                            work <= {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state    <= DivEnd;
                        result_o <= {r_fix, q_fix};
                        ready_o  <= DivResultReady;
                    end
                end

                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end

                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {r,q} and latency queued at issue, checked at ready_o.
module tb_div_unit;

    localparam int W = 32;

    logic           clk          = 1'b0;
    logic           Rst_n        = 1'b1;
    logic           signed_div_i = 1'b0;
    logic [W-1:0]   opdata1_i    = '0;
    logic [W-1:0]   opdata2_i    = '0;
    logic           start_i      = 1'b0;
    logic           annul_i      = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .Rst_n        (Rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) return 64'h0;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Present a request at a negedge; the following posedge is edge 0.
    task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        drive(sgn, a, b);
        exp_q.push_back(model(sgn, a, b));
        lat_q.push_back((b == 32'h0) ? 2 : 33);
    endtask

    task automatic collect(input string tag, input bit scramble);
        logic [63:0] e;
        int          l;
        int          n;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        n = 0;
        @(posedge clk);
        #1;
        if (scramble) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~signed_div_i;
        end
        while (!ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(l));
        chk({tag, " result"}, result_o, e);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
        chk({tag, " hold result"}, result_o, e);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " drop ready"}, 64'(ready_o), 64'd0);
        chk({tag, " drop result"}, result_o, 64'h0);
    endtask

    initial begin
        int n;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;

        #1 Rst_n = 1'b0;
        #1;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'h0);
        repeat (3) @(negedge clk);
        Rst_n = 1'b1;

        issue(1'b0, 32'd100, 32'd7);
        collect("divu 100/7", 1'b0);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        collect("div -7/2", 1'b0);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2);
        collect("divu fff9/2", 1'b0);
        issue(1'b0, 32'h0000_1234, 32'd0);
        collect("by zero", 1'b0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        collect("div ovf scrambled", 1'b1);

        // Annul with cnt==10, then restart right away.
        drive(1'b0, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul on ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        chk("annul on idle ready", 64'(ready_o), 64'd0);
        issue(1'b0, 32'd9, 32'd3);
        collect("restart 9/3", 1'b0);

        // Annul while waiting on a zero divisor.
        drive(1'b0, 32'h0000_1234, 32'd0);
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul bz ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul bz later", 64'(ready_o), 64'd0);

        // Asynchronous reset in the middle of an iteration.
        drive(1'b0, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        Rst_n   = 1'b0;
        start_i = 1'b0;
        #1;
        chk("rst on ready", 64'(ready_o), 64'd0);
        chk("rst on result", result_o, 64'h0);
        @(negedge clk);
        Rst_n = 1'b1;
        issue(1'b0, 32'd200, 32'd9);
        collect("after rst 200/9", 1'b0);

        // Asynchronous reset while a result is being held.
        drive(1'b1, 32'hFFFF_FF9C, 32'd7);
        n = 0;
        @(posedge clk);
        #1;
        while (!ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("end result pre-rst", result_o, model(1'b1, 32'hFFFF_FF9C, 32'd7));
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst end ready", 64'(ready_o), 64'd0);
        chk("rst end result", result_o, 64'h0);
        @(negedge clk);
        start_i = 1'b0;
        Rst_n   = 1'b1;

        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case (i % 4)
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            issue(sgn, a, b);
            collect($sformatf("rand%0d", i), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
